// File: rtl/encoder32to5_stream_pkg.sv
// Shared constants, state encoding and helpers for the 32-to-5 streaming encoder.
package encoder32to5_stream_pkg;

    localparam int WIDTH = 32;
    localparam int IDXW  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Result is IDXW+1 bits wide so an all-ones vector (32) fits.
    function automatic logic [IDXW:0] popcount(input logic [WIDTH-1:0] vec);
        logic [IDXW:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + (IDXW+1)'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/encoder32to5_stream_prio_enc32.sv
// Combinational 32-bit priority encoder: index of the lowest (or highest) set bit,
// plus flags for "any bit set" and "exactly one bit set".
module prio_enc32
    import encoder32to5_stream_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDXW-1:0]  idx,
    output logic             any,
    output logic             single
);

    logic [WIDTH-1:0] vec_m1;

    assign vec_m1 = vec - WIDTH'(1);
    assign any    = |vec;
    assign single = any && ((vec & vec_m1) == '0);

    // The last match in scan order wins, so scan toward the preferred end.
    always_comb begin
        idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) idx = IDXW'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) idx = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/encoder32to5_stream.sv
// Serialises a multi-hot 32-bit vector into a stream of 5-bit set-bit indices
// over valid/ready handshakes on both sides.
module encoder32to5_stream
    import encoder32to5_stream_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic [IDXW:0]    pop_count,
    output logic             empty_pulse
);

    state_t           state, state_next;
    logic [WIDTH-1:0] pend, pend_next;
    logic [IDXW:0]    pop_count_next;
    logic             empty_next;

    logic [IDXW-1:0]  enc_idx;
    logic             enc_any;
    logic             enc_single;
    logic [WIDTH-1:0] clear_mask;

    prio_enc32 #(
        .MSB_FIRST (MSB_FIRST)
    ) u_prio_enc (
        .vec    (pend),
        .idx    (enc_idx),
        .any    (enc_any),
        .single (enc_single)
    );

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == SCAN) && enc_any;
    assign out_idx    = out_valid ? enc_idx : '0;
    assign out_last   = out_valid && enc_single;
    assign clear_mask = WIDTH'(1) << enc_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pend        <= '0;
            pop_count   <= '0;
            empty_pulse <= 1'b0;
        end else begin
            state       <= state_next;
            pend        <= pend_next;
            pop_count   <= pop_count_next;
            empty_pulse <= empty_next;
        end
    end

    // An all-zero vector never enters SCAN; it only raises empty_pulse.
    always_comb begin
        state_next     = state;
        pend_next      = pend;
        pop_count_next = pop_count;
        empty_next     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    pop_count_next = popcount(in_vec);
                    if (in_vec != '0) begin
                        pend_next  = in_vec;
                        state_next = SCAN;
                    end else begin
                        empty_next = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (out_ready) begin
                    pend_next = pend & ~clear_mask;
                    if (enc_single) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_encoder32to5_stream.sv
// Directed self-checking bench for encoder32to5_stream (LSB-first and MSB-first instances).
module tb_encoder32to5_stream;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, empty_pulse;
    logic [31:0] in_vec;
    logic [4:0]  out_idx;
    logic [5:0]  pop_count;

    logic        m_in_valid, m_in_ready, m_out_valid, m_out_last, m_empty_pulse;
    logic [31:0] m_in_vec;
    logic [4:0]  m_out_idx;
    logic [5:0]  m_pop_count;

    int n_asserts = 0;
    int n_fail    = 0;
    int exp_idx[4] = '{0, 2, 8, 31};

    encoder32to5_stream #(.MSB_FIRST(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vec      (in_vec),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .pop_count   (pop_count),
        .empty_pulse (empty_pulse)
    );

    encoder32to5_stream #(.MSB_FIRST(1'b1)) dut_msb (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (m_in_valid),
        .in_ready    (m_in_ready),
        .in_vec      (m_in_vec),
        .out_valid   (m_out_valid),
        .out_ready   (out_ready),
        .out_idx     (m_out_idx),
        .out_last    (m_out_last),
        .pop_count   (m_pop_count),
        .empty_pulse (m_empty_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_vec     = '0;
        out_ready  = 1'b1;
        m_in_valid = 1'b0;
        m_in_vec   = '0;

        // 1. reset then idle
        applyStimulus(2);
        rst = 1'b0;
        applyStimulus(1);
        checkOutput("rst_in_ready",    32'(in_ready),    32'd1);
        checkOutput("rst_out_valid",   32'(out_valid),   32'd0);
        checkOutput("rst_out_idx",     32'(out_idx),     32'd0);
        checkOutput("rst_out_last",    32'(out_last),    32'd0);
        checkOutput("rst_pop_count",   32'(pop_count),   32'd0);
        checkOutput("rst_empty_pulse", 32'(empty_pulse), 32'd0);

        // 2. sparse vector, back-to-back beats
        in_vec   = 32'h8000_0105;
        in_valid = 1'b1;
        applyStimulus(1);
        in_valid = 1'b0;
        checkOutput("sparse_pop_count", 32'(pop_count), 32'd4);
        checkOutput("sparse_in_ready",  32'(in_ready),  32'd0);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("sparse_valid_%0d", k), 32'(out_valid), 32'd1);
            checkOutput($sformatf("sparse_idx_%0d", k),   32'(out_idx),   32'(exp_idx[k]));
            checkOutput($sformatf("sparse_last_%0d", k),  32'(out_last),  (k == 3) ? 32'd1 : 32'd0);
            applyStimulus(1);
        end
        checkOutput("sparse_done_in_ready",  32'(in_ready),  32'd1);
        checkOutput("sparse_done_out_valid", 32'(out_valid), 32'd0);

        // 3. backpressure; in_valid stays high with a different vector during SCAN
        out_ready = 1'b0;
        in_vec    = 32'h0000_0012;
        in_valid  = 1'b1;
        applyStimulus(1);
        in_vec = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("bp_valid_%0d", k), 32'(out_valid), 32'd1);
            checkOutput($sformatf("bp_idx_%0d", k),   32'(out_idx),   32'd1);
            checkOutput($sformatf("bp_last_%0d", k),  32'(out_last),  32'd0);
            applyStimulus(1);
        end
        out_ready = 1'b1;
        checkOutput("bp_rel_idx0",  32'(out_idx),  32'd1);
        checkOutput("bp_rel_last0", 32'(out_last), 32'd0);
        applyStimulus(1);
        checkOutput("bp_rel_idx1",  32'(out_idx),  32'd4);
        checkOutput("bp_rel_last1", 32'(out_last), 32'd1);
        applyStimulus(1);
        in_valid = 1'b0;
        checkOutput("bp_done_in_ready",  32'(in_ready),  32'd1);
        checkOutput("bp_done_out_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_pop_count",      32'(pop_count), 32'd2);

        // 4. full vector then empty vector
        in_vec   = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        applyStimulus(1);
        in_valid = 1'b0;
        checkOutput("full_pop_count", 32'(pop_count), 32'd32);
        for (int k = 0; k < 32; k++) begin
            checkOutput($sformatf("full_valid_%0d", k), 32'(out_valid), 32'd1);
            checkOutput($sformatf("full_idx_%0d", k),   32'(out_idx),   32'(k));
            checkOutput($sformatf("full_last_%0d", k),  32'(out_last),  (k == 31) ? 32'd1 : 32'd0);
            applyStimulus(1);
        end
        checkOutput("full_done_out_valid", 32'(out_valid), 32'd0);
        in_vec   = 32'h0;
        in_valid = 1'b1;
        applyStimulus(1);
        in_valid = 1'b0;
        checkOutput("empty_pulse_hi",   32'(empty_pulse), 32'd1);
        checkOutput("empty_out_valid",  32'(out_valid),   32'd0);
        checkOutput("empty_pop_count",  32'(pop_count),   32'd0);
        checkOutput("empty_in_ready",   32'(in_ready),    32'd1);
        applyStimulus(1);
        checkOutput("empty_pulse_lo",   32'(empty_pulse), 32'd0);
        checkOutput("empty_out_valid2", 32'(out_valid),   32'd0);

        // 5. MSB-first instance
        m_in_vec   = 32'h0000_0081;
        m_in_valid = 1'b1;
        applyStimulus(1);
        m_in_valid = 1'b0;
        checkOutput("msb_valid0", 32'(m_out_valid), 32'd1);
        checkOutput("msb_idx0",   32'(m_out_idx),   32'd7);
        checkOutput("msb_last0",  32'(m_out_last),  32'd0);
        applyStimulus(1);
        checkOutput("msb_idx1",   32'(m_out_idx),   32'd0);
        checkOutput("msb_last1",  32'(m_out_last),  32'd1);
        applyStimulus(1);
        checkOutput("msb_done_valid", 32'(m_out_valid), 32'd0);
        checkOutput("msb_pop_count",  32'(m_pop_count), 32'd2);

        // 6. reset in the middle of a scan
        in_vec   = 32'h0000_00F0;
        in_valid = 1'b1;
        applyStimulus(1);
        in_valid = 1'b0;
        checkOutput("mid_idx0", 32'(out_idx), 32'd4);
        applyStimulus(1);
        checkOutput("mid_idx1", 32'(out_idx), 32'd5);
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_in_ready",  32'(in_ready),  32'd1);
        checkOutput("mid_rst_out_idx",   32'(out_idx),   32'd0);
        checkOutput("mid_rst_pop_count", 32'(pop_count), 32'd0);
        applyStimulus(1);
        checkOutput("mid_rst_stays_idle", 32'(out_valid), 32'd0);
        in_vec   = 32'h0000_0001;
        in_valid = 1'b1;
        applyStimulus(1);
        in_valid = 1'b0;
        checkOutput("single_valid",     32'(out_valid), 32'd1);
        checkOutput("single_idx",       32'(out_idx),   32'd0);
        checkOutput("single_last",      32'(out_last),  32'd1);
        checkOutput("single_pop_count", 32'(pop_count), 32'd1);
        applyStimulus(1);
        checkOutput("single_done_valid",    32'(out_valid), 32'd0);
        checkOutput("single_done_in_ready", 32'(in_ready),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
